mult_share_arbiter: RTL and testbench
=====================================

// Module: mult_share_arbiter
// PURPOSE
// - Shares one unsigned WIDTH x WIDTH shift-add multiplier datapath among NREQ requesters.
// - Arbitration is round-robin, with a valid/ready handshake per requester.
// - Products return in issue order through an output FIFO, tagged with the requester id.
// - Sits between the compute lanes and the single multiplier instance, replacing per-lane multipliers.
// PARAMETERS
// NREQ   4  number of requesters (>=2)
// WIDTH  8  operand width; product width is 2*WIDTH
// PIPE   1  multiplier latency in cycles, from issue to product valid (>=1)
// DEPTH  4  output FIFO entries; also the maximum number of outstanding operations (>=PIPE)
// (localparam IDW = $clog2(NREQ))
// PORTS
// clk         in   1            clock, all flops rising edge
// rstn        in   1            asynchronous active-low reset
// req_valid   in   NREQ         requester i has an operation pending
// req_a       in   NREQ*WIDTH   operand a, lane i at [i*WIDTH +: WIDTH]
// req_b       in   NREQ*WIDTH   operand b, same packing
// req_ready   out  NREQ         one-hot grant; a handshake occurs when req_valid[i] && req_ready[i]
// rsp_valid   out  1            FIFO head holds a result
// rsp_ready   in   1            consumer accepts the head
// rsp_id      out  IDW          requester index of the head
// rsp_result  out  2*WIDTH      a*b, unsigned and exact, no truncation
// busy        out  1            outstanding count != 0
// BEHAVIOUR
// - Reset (async, any time): the following are all cleared.
//   - RR pointer to 0.
//   - Pipe valid bits.
//   - FIFO read/write pointers and count.
//   - Outstanding counter.
//   - Outputs: rsp_valid=0, req_ready=0, busy=0, rsp_id=0, rsp_result=0.
//   - In-flight operations are discarded and never reported.
// - Issue condition: at least one req_valid is set and outstanding < DEPTH.
// - Grant selection:
//   - Pick the first valid requester, searching from ptr upward modulo NREQ.
//   - req_ready is combinational from req_valid, ptr and outstanding, and is at most one-hot.
//   - req_ready is all zero when the issue condition fails.
// - On issue:
//   - ptr <= granted + 1 (wraps from NREQ-1 to 0).
//   - Operands and id enter pipe stage 0.
// - On no issue: ptr holds.
// - Requester side: a requester holds req_a, req_b and req_valid until granted.
// - Pipeline:
//   - Product, id and valid shift one stage per cycle and are never stalled.
//   - The product lands in the FIFO exactly PIPE cycles after issue.
//   - Earliest rsp_valid: cycle issue+PIPE (FIFO empty, no bypass).
// - Credit counting:
//   - outstanding = in-pipe ops + FIFO count.
//   - +1 on issue, -1 on pop; simultaneous issue and pop leave it unchanged.
//   - This guarantees the FIFO never overflows. FIFO write while full is an assertion failure.
// - FIFO behaviour:
//   - Pop when rsp_valid && rsp_ready. rsp_* show the head combinationally.
//   - rsp_id=0 and rsp_result=0 whenever the FIFO is empty.
//   - Simultaneous write and pop when full or empty are both legal.
//   - Pointers wrap modulo DEPTH.
// - Ordering: responses leave in issue order. Each requester's responses are therefore in its own request order.
// - Fairness: with all NREQ valid and rsp_ready held at 1, grants cycle 0,1,..,NREQ-1,0 with no starvation.
// - rsp_ready=0 with a valid head: the head and rsp_* stay stable until popped.
// STRUCTURE
// - Shared package: WIDTH default, product width function, id-width function.
// - Sub-module mult_core (WIDTH, PIPE):
//   - Ports: clk, rstn, in_valid, a, b, in_id, out_valid, out_id, out_p.
//   - Datapath: partial products b[k] ? a<<k : 0, summed, then registered through PIPE stages.
// - Top module contains the RR arbiter, the credit counter and the FIFO (register array).
// TESTING
// - Reset then single op: req0 a=8'd13, b=8'd11 -> req_ready[0] same cycle; after PIPE cycles rsp_valid=1, rsp_id=0, rsp_result=143.
// - Corners: a=255,b=255 -> 65025; a=0,b=200 -> 0; a=1,b=128 -> 128; a=128,b=2 -> 256.
// - All 4 valid every cycle, rsp_ready=1 -> grant order 0,1,2,3,0,1; responses match ids in that order; each id granted once per 4 cycles.
// - rsp_ready=0, req1 always valid -> exactly DEPTH=4 grants, then req_ready=0 and busy=1.
//   Raise rsp_ready for 1 cycle -> exactly one new grant. No FIFO overflow.
// - Full sweep: a,b in 0..255 via rotating requesters vs a model product -> zero mismatches; ids correct.
// - Assert rstn low with 3 ops in flight -> rsp_valid=0 and busy=0 immediately, with no stale response after release.
//   A new op after release (a=7, b=9) -> 63 with the correct id.

Source files
------------

// File: rtl/mult_share_arbiter_pkg.sv
// Shared definitions for the multiplier-sharing arbiter.
// Widths derived from operand width and requester count.
package mult_share_arbiter_pkg;

  localparam int WIDTH_DEF = 8;

  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mult_core.sv
// Shift-add unsigned multiplier carrying a valid bit and tag.
// The arbiter's FIFO slot is the final register of the pipe.
module mult_core
  import mult_share_arbiter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int PIPE  = 1,
  parameter int IDW   = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  input  logic [IDW-1:0]           in_id,
  output logic                     out_valid,
  output logic [IDW-1:0]           out_id,
  output logic [prod_w(WIDTH)-1:0] out_p
);

  localparam int PW = prod_w(WIDTH);

  logic [PW-1:0] prod;

  always_comb begin
    prod = '0;
    for (int k = 0; k < WIDTH; k++) begin
      if (b[k]) prod = prod + (PW'(a) << k);
    end
  end

  generate
    if (PIPE == 1) begin : g_comb
      logic unused_clk;
      assign unused_clk = clk ^ rstn;
      assign out_valid  = in_valid;
      assign out_id     = in_id;
      assign out_p      = prod;
    end else begin : g_pipe
      logic [PIPE-2:0] v_q;
      logic [IDW-1:0]  id_q [PIPE-1];
      logic [PW-1:0]   p_q  [PIPE-1];

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          v_q <= '0;
          for (int s = 0; s < PIPE - 1; s++) begin
            id_q[s] <= '0;
            p_q[s]  <= '0;
          end
        end else begin
          v_q[0]  <= in_valid;
          id_q[0] <= in_id;
          p_q[0]  <= prod;
          for (int s = 1; s < PIPE - 1; s++) begin
            v_q[s]  <= v_q[s-1];
            id_q[s] <= id_q[s-1];
            p_q[s]  <= p_q[s-1];
          end
        end
      end

      assign out_valid = v_q[PIPE-2];
      assign out_id    = id_q[PIPE-2];
      assign out_p     = p_q[PIPE-2];
    end
  endgenerate

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one multiplier among NREQ lanes.
// Credits bound in-flight work so the result FIFO cannot overflow.
module mult_share_arbiter
  import mult_share_arbiter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = WIDTH_DEF,
  parameter int PIPE  = 1,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*WIDTH-1:0]    req_a,
  input  logic [NREQ*WIDTH-1:0]    req_b,
  output logic [NREQ-1:0]          req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [id_w(NREQ)-1:0]    rsp_id,
  output logic [prod_w(WIDTH)-1:0] rsp_result,
  output logic                     busy
);

  localparam int IDW = id_w(NREQ);
  localparam int PW  = prod_w(WIDTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int FW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [IDW-1:0]  ptr_q;
  logic [IDW-1:0]  gnt_id;
  logic [NREQ-1:0] gnt_oh;
  logic            found;
  logic            issue;
  int              idx;

  logic [CW-1:0]   out_q;
  logic [CW-1:0]   cnt_q;
  logic [FW-1:0]   wp_q;
  logic [FW-1:0]   rp_q;
  logic [IDW-1:0]  id_mem [DEPTH];
  logic [PW-1:0]   p_mem  [DEPTH];

  logic            wr;
  logic            pop;
  logic            full;
  logic [IDW-1:0]  c_id;
  logic [PW-1:0]   c_p;

  // First valid lane at or above the pointer, wrapping
  always_comb begin
    gnt_oh = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid[idx[IDW-1:0]]) begin
        found               = 1'b1;
        gnt_oh[idx[IDW-1:0]] = 1'b1;
        gnt_id              = idx[IDW-1:0];
      end
    end
  end

  assign issue     = rstn && found && (out_q < CW'(DEPTH));
  assign req_ready = issue ? gnt_oh : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q <= '0;
    end else if (issue) begin
      ptr_q <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
    end
  end

  mult_core #(
    .WIDTH (WIDTH),
    .PIPE  (PIPE),
    .IDW   (IDW)
  ) u_core (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (issue),
    .a         (req_a[int'(gnt_id)*WIDTH +: WIDTH]),
    .b         (req_b[int'(gnt_id)*WIDTH +: WIDTH]),
    .in_id     (gnt_id),
    .out_valid (wr),
    .out_id    (c_id),
    .out_p     (c_p)
  );

  assign rsp_valid  = (cnt_q != '0);
  assign pop        = rsp_valid && rsp_ready;
  assign full       = (cnt_q == CW'(DEPTH));
  assign rsp_id     = rsp_valid ? id_mem[rp_q] : '0;
  assign rsp_result = rsp_valid ? p_mem[rp_q] : '0;
  assign busy       = (out_q != '0);

  always_ff @(posedge clk) begin
    if (wr) begin
      id_mem[wp_q] <= c_id;
      p_mem[wp_q]  <= c_p;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      out_q <= '0;
    end else begin
      if (wr)
        wp_q <= (wp_q == FW'(DEPTH - 1)) ? '0 : wp_q + 1'b1;
      if (pop)
        rp_q <= (rp_q == FW'(DEPTH - 1)) ? '0 : rp_q + 1'b1;
      unique case ({wr, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      unique case ({issue, pop})
        2'b10:   out_q <= out_q + 1'b1;
        2'b01:   out_q <= out_q - 1'b1;
        default: out_q <= out_q;
      endcase
    end
  end

  a_no_ovf: assert property (@(posedge clk) disable iff (!rstn) !(wr && full));

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench: vector table, corner sequences, and random
// traffic against a queue-based model of issue order and latency.
module tb_mult_share_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int PIPE  = 1;
  localparam int DEPTH = 4;

  logic                    clk = 1'b0;
  logic                    rstn;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ*WIDTH-1:0]   req_a;
  logic [NREQ*WIDTH-1:0]   req_b;
  logic [NREQ-1:0]         req_ready;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [1:0]              rsp_id;
  logic [2*WIDTH-1:0]      rsp_result;
  logic                    busy;

  mult_share_arbiter #(
    .NREQ (NREQ), .WIDTH (WIDTH), .PIPE (PIPE), .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int p;
    int due;
  } op_t;

  typedef struct {
    int lane;
    int a;
    int b;
    int exp;
  } vec_t;

  int checks = 0;
  int errors = 0;
  op_t pipe_q[$];
  op_t fifo_q[$];
  int mptr;
  int mout;
  int cyc;
  int last_grant;
  logic [NREQ-1:0] dut_rr;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    pipe_q.delete();
    fifo_q.delete();
    mptr = 0;
    mout = 0;
  endtask

  function automatic int pick();
    int r;
    r = int'($urandom_range(0, 7));
    if (r == 0) return 0;
    if (r == 1) return 255;
    return int'($urandom_range(0, 255));
  endfunction

  task automatic set_op(input int l, input int a, input int b);
    req_valid[l] = 1'b1;
    req_a[l*WIDTH +: WIDTH] = a[WIDTH-1:0];
    req_b[l*WIDTH +: WIDTH] = b[WIDTH-1:0];
  endtask

  // One clock: compare against the model, then advance both
  task automatic step();
    int g;
    int idx;
    logic [NREQ-1:0] er;
    op_t o;
    #1;
    g = -1;
    if (mout < DEPTH) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (mptr + k) % NREQ;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    dut_rr = req_ready;
    chk("req_ready", req_ready, er);
    chk("rsp_valid", rsp_valid, fifo_q.size() != 0);
    if (fifo_q.size() != 0) begin
      chk("rsp_id", rsp_id, fifo_q[0].id);
      chk("rsp_result", rsp_result, fifo_q[0].p);
    end else begin
      chk("rsp_id_empty", rsp_id, 0);
      chk("rsp_result_empty", rsp_result, 0);
    end
    chk("busy", busy, mout != 0);
    last_grant = g;
    if (g >= 0) begin
      o.id  = g;
      o.p   = int'(req_a[g*WIDTH +: WIDTH]) * int'(req_b[g*WIDTH +: WIDTH]);
      o.due = cyc + PIPE;
      pipe_q.push_back(o);
      mptr = (g + 1) % NREQ;
      mout++;
    end
    if (fifo_q.size() != 0 && rsp_ready) begin
      void'(fifo_q.pop_front());
      mout--;
    end
    @(posedge clk);
    #1;
    cyc++;
    while (pipe_q.size() != 0 && pipe_q[0].due <= cyc)
      fifo_q.push_back(pipe_q.pop_front());
  endtask

  task automatic drain();
    int n;
    req_valid = '0;
    rsp_ready = 1'b1;
    n = 0;
    while (mout != 0 && n < 50) begin
      step();
      n++;
    end
    chk("drain", mout, 0);
  endtask

  vec_t vecs[6];
  int order[6];
  int ng;

  initial begin
    vecs[0] = '{0, 13, 11, 143};
    vecs[1] = '{1, 255, 255, 65025};
    vecs[2] = '{2, 0, 200, 0};
    vecs[3] = '{3, 1, 128, 128};
    vecs[4] = '{2, 128, 2, 256};
    vecs[5] = '{3, 7, 9, 63};
    order   = '{0, 1, 2, 3, 0, 1};

    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    rstn      = 1'b0;
    cyc       = 0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    req_valid = '1;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_result", rsp_result, 0);
    req_valid = '0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Single operations from the vector table
    foreach (vecs[i]) begin
      set_op(vecs[i].lane, vecs[i].a, vecs[i].b);
      if (i == 0) begin
        #1;
        chk("first_grant", req_ready, 1);
      end
      step();
      req_valid = '0;
      chk("vec_valid", rsp_valid, 1);
      chk("vec_id", rsp_id, vecs[i].lane);
      chk("vec_result", rsp_result, vecs[i].exp);
      step();
    end
    drain();

    // Fairness with every lane requesting
    for (int l = 0; l < NREQ; l++) set_op(l, pick(), pick());
    for (int i = 0; i < 6; i++) begin
      step();
      chk("fair_grant", dut_rr, 1 << order[i]);
      if (last_grant >= 0) set_op(last_grant, pick(), pick());
    end
    drain();

    // Backpressure: credits stop issue at DEPTH
    rsp_ready = 1'b0;
    set_op(1, pick(), pick());
    ng = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (dut_rr[1]) begin
        ng++;
        set_op(1, pick(), pick());
      end
    end
    chk("bp_grants", ng, DEPTH);
    chk("bp_busy", busy, 1);
    chk("bp_ready_low", req_ready, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    ng = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (dut_rr[1]) begin
        ng++;
        set_op(1, pick(), pick());
      end
    end
    chk("bp_one_more", ng, 1);
    drain();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      for (int l = 0; l < NREQ; l++)
        if (!req_valid[l] && $urandom_range(0, 1) == 1)
          set_op(l, pick(), pick());
      rsp_ready = ($urandom_range(0, 9) < 7);
      step();
      if (last_grant >= 0) begin
        req_valid[last_grant] = 1'b0;
        if ($urandom_range(0, 1) == 1)
          set_op(last_grant, pick(), pick());
      end
    end
    drain();

    // Reset with work in flight
    rsp_ready = 1'b0;
    for (int l = 0; l < NREQ; l++) set_op(l, pick(), pick());
    for (int i = 0; i < 3; i++) begin
      step();
      if (last_grant >= 0) set_op(last_grant, pick(), pick());
    end
    #2;
    rstn = 1'b0;
    #1;
    chk("ar_rsp_valid", rsp_valid, 0);
    chk("ar_busy", busy, 0);
    chk("ar_req_ready", req_ready, 0);
    model_reset();
    req_valid = '0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    set_op(2, 7, 9);
    step();
    req_valid = '0;
    chk("post_rst_valid", rsp_valid, 1);
    chk("post_rst_id", rsp_id, 2);
    chk("post_rst_result", rsp_result, 63);
    step();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
